pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen.sv | 146 ++++++++++++++
 tb/tb_pwm_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
//
// Pulse-width modulator driven by an external free-running up-counter that
// sweeps 0..UPBND. The output period is one full sweep of that counter, and
// the high time is taken from an active duty register that only changes at
// a period boundary. New duty values pass through a single pending slot.
//
// Ports
//   i_clk       : clock, all state updates on the rising edge
//   i_rst       : synchronous, active-high reset
//   i_en        : run request (level)
//   i_cnt       : upstream counter value, CW bits
//   i_duty      : requested high time in counts, DW bits (clamped to UPBND+1)
//   i_duty_vld  : i_duty valid
//   o_duty_rdy  : pending slot free
//   o_pwm       : registered PWM output
//   o_prd_end   : registered one-cycle pulse at the end of an output period
//   o_busy      : high whenever the FSM is not in IDLE
//
// Duty handshake: a value is taken on every rising edge where
// i_duty_vld && o_duty_rdy. o_duty_rdy depends only on the pending-slot flop,
// never on i_duty_vld, so the source may hold i_duty_vld high and wait.
// -----------------------------------------------------------------------------
module pwm_gen #(
    parameter int UPBND = 15,
    localparam int CW = $clog2(UPBND + 1),
    localparam int DW = $clog2(UPBND + 2)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [CW-1:0] i_cnt,
    input  logic [DW-1:0] i_duty,
    input  logic          i_duty_vld,
    output logic          o_duty_rdy,
    output logic          o_pwm,
    output logic          o_prd_end,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam logic [DW-1:0] DUTY_MAX = DW'(UPBND + 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(UPBND);

    state_e        state_q, state_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    logic [DW-1:0] duty_pnd_q, duty_pnd_d;
    logic          pnd_vld_q, pnd_vld_d;
    logic          pwm_q, pwm_d;
    logic          prd_end_q, prd_end_d;

    logic          wrap;
    logic          active;
    logic          accept;
    logic          transfer;
    logic [DW-1:0] cnt_ext;
    logic [DW-1:0] duty_clamped;

    // Decode of the current cycle
    always_comb begin
        wrap         = (i_cnt == CNT_TOP);
        active       = (state_q == RUN) || (state_q == STOP);
        cnt_ext      = DW'(i_cnt);
        duty_clamped = (i_duty > DUTY_MAX) ? DUTY_MAX : i_duty;
        accept       = i_duty_vld && !pnd_vld_q;
        // In IDLE no period is running, so a pending duty moves over at once.
        // Otherwise it waits for the last count of the period so the new
        // value governs the compare starting at i_cnt = 0.
        transfer     = pnd_vld_q && ((state_q == IDLE) || wrap);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_en) state_d = ARM;
            end
            ARM: begin
                if (!i_en)     state_d = IDLE;
                else if (wrap) state_d = RUN;
            end
            RUN: begin
                if (!i_en) state_d = wrap ? IDLE : STOP;
            end
            STOP: begin
                // STOP keeps comparing, so a return to RUN needs no realignment
                if (wrap)      state_d = IDLE;
                else if (i_en) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Duty pipeline and registered outputs
    always_comb begin
        duty_act_d = duty_act_q;
        duty_pnd_d = duty_pnd_q;
        pnd_vld_d  = pnd_vld_q;

        // accept and transfer are mutually exclusive: accept needs the slot
        // empty, transfer needs it full.
        if (transfer) begin
            duty_act_d = duty_pnd_q;
            pnd_vld_d  = 1'b0;
        end else if (accept) begin
            duty_pnd_d = duty_clamped;
            pnd_vld_d  = 1'b1;
        end

        // Compare uses the duty in force this cycle, before any transfer
        pwm_d     = active && (cnt_ext < duty_act_q);
        prd_end_d = active && wrap;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            duty_act_q <= '0;
            duty_pnd_q <= '0;
            pnd_vld_q  <= 1'b0;
            pwm_q      <= 1'b0;
            prd_end_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_act_q <= duty_act_d;
            duty_pnd_q <= duty_pnd_d;
            pnd_vld_q  <= pnd_vld_d;
            pwm_q      <= pwm_d;
            prd_end_q  <= prd_end_d;
        end
    end

    assign o_pwm      = pwm_q;
    assign o_prd_end  = prd_end_q;
    assign o_busy     = (state_q != IDLE);
    assign o_duty_rdy = !pnd_vld_q;

endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
//
// Bench for pwm_gen with UPBND = 15. The bench owns the upstream counter and
// advances it on every falling edge. A reference model of the block's rules
// steps on each rising edge and its outputs are compared 1 time unit later.
// Directed scenarios add literal expectations on period-level behaviour,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_pwm_gen;

  localparam int UPBND = 15;
  localparam int CW    = $clog2(UPBND + 1);
  localparam int DW    = $clog2(UPBND + 2);

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] cnt;
  logic [DW-1:0] duty;
  logic          duty_vld;
  logic          duty_rdy;
  logic          pwm;
  logic          prd_end;
  logic          busy;

  always #5 clk = ~clk;

  pwm_gen #(.UPBND(UPBND)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_cnt      (cnt),
    .i_duty     (duty),
    .i_duty_vld (duty_vld),
    .o_duty_rdy (duty_rdy),
    .o_pwm      (pwm),
    .o_prd_end  (prd_end),
    .o_busy     (busy)
  );

  // ---------------------------------------------------------------- scoring
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  // mode: 0 idle, 1 arming (waiting for a sweep start), 2 running,
  // 3 running with stop requested
  int m_mode;
  int m_act;
  int m_pnd;
  bit m_pv;
  bit m_pwm;
  bit m_pe;
  bit m_running;
  bit m_wrap;
  int m_c;
  int m_d;

  always @(posedge clk) begin
    m_c    = int'(cnt);
    m_d    = int'(duty);
    m_wrap = (m_c == UPBND);
    if (rst) begin
      m_mode = 0; m_act = 0; m_pnd = 0; m_pv = 0; m_pwm = 0; m_pe = 0;
    end else begin
      m_running = (m_mode >= 2);
      m_pwm     = m_running && (m_c < m_act);
      m_pe      = m_running && m_wrap;
      if (m_pv && (m_mode == 0 || m_wrap)) begin
        m_act = m_pnd;
        m_pv  = 0;
      end else if (!m_pv && duty_vld) begin
        m_pnd = (m_d > UPBND + 1) ? UPBND + 1 : m_d;
        m_pv  = 1;
      end
      if (m_mode == 0)      m_mode = en ? 1 : 0;
      else if (m_mode == 1) m_mode = !en ? 0 : (m_wrap ? 2 : 1);
      else if (m_mode == 2) m_mode = en ? 2 : (m_wrap ? 0 : 3);
      else                  m_mode = m_wrap ? 0 : (en ? 2 : 3);
    end
    #1;
    check("pwm",      int'(pwm),      int'(m_pwm));
    check("prd_end",  int'(prd_end),  int'(m_pe));
    check("busy",     int'(busy),     int'(m_mode != 0));
    check("duty_rdy", int'(duty_rdy), int'(!m_pv));
  end

  // ---------------------------------------------------------------- drivers
  // Advance one cycle; the counter changes on the falling edge
  task automatic tick();
    @(negedge clk);
    cnt = (int'(cnt) == UPBND) ? '0 : cnt + 1'b1;
  endtask

  // Tick until the counter shows v (the value the next rising edge samples)
  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (int'(cnt) != v && n < 40);
    if (int'(cnt) != v) check("wait_cnt_timeout", int'(cnt), v);
  endtask

  task automatic load_duty(input int v);
    check("rdy_before_load", int'(duty_rdy), 1);
    duty     = DW'(v);
    duty_vld = 1'b1;
    tick();
    duty_vld = 1'b0;
  endtask

  // Observe the outputs produced by the edges sampling i_cnt = 0..15
  task automatic measure_period(output int highs, output int ends);
    wait_cnt(1);
    highs = int'(pwm);
    ends  = int'(prd_end);
    repeat (15) begin
      tick();
      highs += int'(pwm);
      ends  += int'(prd_end);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  int h, e;

  initial begin
    rst = 1'b1; en = 1'b0; cnt = '0; duty = '0; duty_vld = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_pwm",     int'(pwm),      0);
    check("reset_prd_end", int'(prd_end),  0);
    check("reset_busy",    int'(busy),     0);
    check("reset_rdy",     int'(duty_rdy), 1);

    // Basic PWM at duty 4
    load_duty(4);
    en = 1'b1;
    measure_period(h, e);
    measure_period(h, e);
    check("basic_highs", h, 4);
    check("basic_ends",  e, 1);
    check("basic_busy",  int'(busy), 1);
    wait_cnt(1);
    check("basic_pwm_after_cnt0", int'(pwm), 1);
    wait_cnt(5);
    check("basic_pwm_after_cnt4", int'(pwm), 0);
    wait_cnt(0);

    // Mid-period update to 10 at i_cnt = 6
    wait_cnt(6);
    load_duty(10);
    check("mid_rdy_drop", int'(duty_rdy), 0);
    wait_cnt(15);
    check("mid_rdy_held", int'(duty_rdy), 0);
    wait_cnt(0);
    check("mid_rdy_back", int'(duty_rdy), 1);
    measure_period(h, e);
    check("mid_new_highs", h, 10);

    // Accept exactly on the wrap cycle
    wait_cnt(15);
    load_duty(8);
    check("wrap_rdy_drop", int'(duty_rdy), 0);
    measure_period(h, e);
    check("wrap_old_highs", h, 10);
    measure_period(h, e);
    check("wrap_new_highs", h, 8);

    // Graceful stop at i_cnt = 2
    wait_cnt(2);
    en = 1'b0;
    tick();
    check("stop_busy", int'(busy), 1);
    wait_cnt(0);
    check("stop_prd_end", int'(prd_end), 1);
    check("stop_busy_fall", int'(busy), 0);

    // Second run, drop at 2 and re-raise at 9
    en = 1'b1;
    wait_cnt(1);
    wait_cnt(0);
    wait_cnt(2);
    en = 1'b0;
    tick();
    wait_cnt(9);
    en = 1'b1;
    tick();
    check("resume_busy", int'(busy), 1);
    wait_cnt(0);
    check("resume_prd_end", int'(prd_end), 1);
    check("resume_busy_wrap", int'(busy), 1);
    measure_period(h, e);
    check("resume_highs", h, 8);
    check("resume_ends",  e, 1);

    // Extremes
    load_duty(0);
    measure_period(h, e);
    measure_period(h, e);
    check("duty0_highs", h, 0);
    load_duty(20);
    measure_period(h, e);
    measure_period(h, e);
    check("duty20_highs", h, 16);
    check("duty20_ends",  e, 1);

    // Reset mid-period with a pending value that must be discarded
    wait_cnt(1);
    duty = DW'(12); duty_vld = 1'b1;
    tick();
    duty_vld = 1'b0;
    check("prerst_pwm", int'(pwm), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_pwm",  int'(pwm),      0);
    check("rst_mid_busy", int'(busy),     0);
    check("rst_mid_rdy",  int'(duty_rdy), 1);
    measure_period(h, e);
    measure_period(h, e);
    check("restart_highs", h, 0);
    check("restart_ends",  e, 1);

    // Randomized run
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 19) == 0) en = !en;
      rst      = ($urandom_range(0, 399) == 0);
      duty_vld = ($urandom_range(0, 3) == 0);
      duty     = DW'($urandom_range(0, 31));
    end
    rst = 1'b0; duty_vld = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
